// File: rtl/cpu31_pkg.sv
// rtl/cpu31_pkg.sv - shared constants, encodings and types for the cpu31 control unit
// Ports: none (package).

package cpu31_pkg;

  localparam int ALUC_W = 5;

  // ALU opcodes
  localparam logic [ALUC_W-1:0] ALU_ADDU = 5'b00000;
  localparam logic [ALUC_W-1:0] ALU_ADD  = 5'b00001;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [ALUC_W-1:0] ALU_SUBU = 5'b00011;
  localparam logic [ALUC_W-1:0] ALU_AND  = 5'b00100;
  localparam logic [ALUC_W-1:0] ALU_OR   = 5'b00101;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 5'b00110;
  localparam logic [ALUC_W-1:0] ALU_NOR  = 5'b00111;
  localparam logic [ALUC_W-1:0] ALU_SLL  = 5'b01000;
  localparam logic [ALUC_W-1:0] ALU_SRL  = 5'b01001;
  localparam logic [ALUC_W-1:0] ALU_SRA  = 5'b01010;
  localparam logic [ALUC_W-1:0] ALU_SLLV = 5'b01011;
  localparam logic [ALUC_W-1:0] ALU_LUI  = 5'b01101;
  localparam logic [ALUC_W-1:0] ALU_SRLV = 5'b01110;
  localparam logic [ALUC_W-1:0] ALU_SRAV = 5'b01111;
  localparam logic [ALUC_W-1:0] ALU_MEM  = 5'b10001;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 5'b10010;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 5'b10011;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Datapath select codes
  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_RS  = 2'd3;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_RA  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR} iclass_t;

  // Only the signed add/sub opcodes may raise an overflow trap.
  function automatic logic can_trap(input logic [ALUC_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cpu31_if.sv
// rtl/cpu31_if.sv - control/datapath/memory signal bundle for the cpu31 control unit
// Ports: none; modport master = control unit, modport slave = datapath/memory side.

interface cpu31_if;
  logic [31:0]                   instr;
  logic                          alu_zero;
  logic                          alu_overflow;
  logic                          mem_ack;
  logic                          mem_req;
  logic                          mem_we;
  logic                          iord;
  logic                          ir_we;
  logic                          pc_we;
  logic [1:0]                    pc_sel;
  logic [cpu31_pkg::ALUC_W-1:0]  aluc;
  logic                          a_sel;
  logic                          b_sel;
  logic                          ext_sign;
  logic                          aluo_we;
  logic                          rf_we;
  logic [1:0]                    rf_dst;
  logic [1:0]                    wb_sel;
  logic                          ovf_trap;
  logic                          halted;

  modport master (
    input  instr, alu_zero, alu_overflow, mem_ack,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_sel, aluc, a_sel, b_sel,
           ext_sign, aluo_we, rf_we, rf_dst, wb_sel, ovf_trap, halted
  );

  modport slave (
    output instr, alu_zero, alu_overflow, mem_ack,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_sel, aluc, a_sel, b_sel,
           ext_sign, aluo_we, rf_we, rf_dst, wb_sel, ovf_trap, halted
  );
endinterface

// File: rtl/cpu31_decode.sv
// rtl/cpu31_decode.sv - combinational opcode/funct decoder
// Ports: opcode, funct in; iclass, aluc, a_sel, b_sel, ext_sign, rf_dst, illegal out.

module cpu31_decode
  import cpu31_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output iclass_t           iclass,
  output logic [ALUC_W-1:0] aluc,
  output logic              a_sel,
  output logic              b_sel,
  output logic              ext_sign,
  output logic [1:0]        rf_dst,
  output logic              illegal
);

  always_comb begin
    iclass   = C_ALU;
    aluc     = ALU_ADDU;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    ext_sign = 1'b1;
    rf_dst   = RD_RT;
    illegal  = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        rf_dst = RD_RD;
        case (funct)
          F_ADD:  aluc = ALU_ADD;
          F_ADDU: aluc = ALU_ADDU;
          F_SUB:  aluc = ALU_SUB;
          F_SUBU: aluc = ALU_SUBU;
          F_AND:  aluc = ALU_AND;
          F_OR:   aluc = ALU_OR;
          F_XOR:  aluc = ALU_XOR;
          F_NOR:  aluc = ALU_NOR;
          F_SLT:  aluc = ALU_SLT;
          F_SLTU: aluc = ALU_SLTU;
          // Constant shifts feed shamt on operand A; the ALU shifts by all of A.
          F_SLL:  begin aluc = ALU_SLL; a_sel = 1'b1; end
          F_SRL:  begin aluc = ALU_SRL; a_sel = 1'b1; end
          F_SRA:  begin aluc = ALU_SRA; a_sel = 1'b1; end
          F_SLLV: aluc = ALU_SLLV;
          F_SRLV: aluc = ALU_SRLV;
          F_SRAV: aluc = ALU_SRAV;
          F_JR:   iclass = C_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_J:     iclass = C_J;
      OP_JAL:   begin iclass = C_JAL; rf_dst = RD_RA; end
      // SUBU compare so a branch can never raise overflow.
      OP_BEQ:   begin iclass = C_BEQ; aluc = ALU_SUBU; end
      OP_BNE:   begin iclass = C_BNE; aluc = ALU_SUBU; end
      OP_ADDI:  begin aluc = ALU_ADD;  b_sel = 1'b1; end
      OP_ADDIU: begin aluc = ALU_ADDU; b_sel = 1'b1; end
      OP_SLTI:  begin aluc = ALU_SLT;  b_sel = 1'b1; end
      OP_SLTIU: begin aluc = ALU_SLTU; b_sel = 1'b1; end
      OP_ANDI:  begin aluc = ALU_AND;  b_sel = 1'b1; ext_sign = 1'b0; end
      OP_ORI:   begin aluc = ALU_OR;   b_sel = 1'b1; ext_sign = 1'b0; end
      OP_XORI:  begin aluc = ALU_XOR;  b_sel = 1'b1; ext_sign = 1'b0; end
      OP_LUI:   begin aluc = ALU_LUI;  b_sel = 1'b1; end
      OP_LW:    begin iclass = C_LW; aluc = ALU_MEM; b_sel = 1'b1; end
      OP_SW:    begin iclass = C_SW; aluc = ALU_MEM; b_sel = 1'b1; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu31_ctrl.sv
// rtl/cpu31_ctrl.sv - multicycle IF/ID/EX/MEM/WB sequencer with overflow trap and halt
// Ports: clk, rst (sync, active-high); bus (cpu31_if.master): instr, alu_zero,
//        alu_overflow, mem_ack in; memory, PC/IR, ALU select and writeback strobes out.

module cpu31_ctrl
  import cpu31_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  cpu31_if.master   bus
);

  state_t            state, state_nx;
  logic              ovf_q, ovf_nx;

  iclass_t           d_iclass;
  logic [ALUC_W-1:0] d_aluc;
  logic              d_a_sel;
  logic              d_b_sel;
  logic              d_ext_sign;
  logic [1:0]        d_rf_dst;
  logic              d_illegal;
  logic              br_take;

  cpu31_decode u_decode (
    .opcode   (bus.instr[31:26]),
    .funct    (bus.instr[5:0]),
    .iclass   (d_iclass),
    .aluc     (d_aluc),
    .a_sel    (d_a_sel),
    .b_sel    (d_b_sel),
    .ext_sign (d_ext_sign),
    .rf_dst   (d_rf_dst),
    .illegal  (d_illegal)
  );

  assign br_take = bus.alu_zero ^ (d_iclass == C_BNE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      ovf_q <= ovf_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ovf_nx       = ovf_q;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.iord     = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = PC_INC;
    bus.aluc     = '0;
    bus.a_sel    = 1'b0;
    bus.b_sel    = 1'b0;
    bus.ext_sign = 1'b0;
    bus.aluo_we  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_dst   = RD_RT;
    bus.wb_sel   = WB_ALU;
    bus.ovf_trap = 1'b0;
    bus.halted   = 1'b0;

    case (state)
      S_IF: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_nx  = S_ID;
        end
      end
      S_ID: begin
        if (d_illegal) begin
          state_nx = S_HALT;
        end else begin
          case (d_iclass)
            C_J: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PC_JMP;
              state_nx   = S_IF;
            end
            C_JAL: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PC_JMP;
              bus.rf_we  = 1'b1;
              bus.wb_sel = WB_PC;
              bus.rf_dst = RD_RA;
              state_nx   = S_IF;
            end
            C_JR: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PC_RS;
              state_nx   = S_IF;
            end
            default: state_nx = S_EX;
          endcase
        end
      end
      S_EX: begin
        bus.aluc     = d_aluc;
        bus.a_sel    = d_a_sel;
        bus.b_sel    = d_b_sel;
        bus.ext_sign = d_ext_sign;
        bus.aluo_we  = 1'b1;
        ovf_nx       = bus.alu_overflow & can_trap(d_aluc);
        case (d_iclass)
          C_BEQ, C_BNE: begin
            bus.pc_we  = br_take;
            bus.pc_sel = br_take ? PC_BR : PC_INC;
            state_nx   = S_IF;
          end
          C_LW, C_SW: state_nx = S_MEM;
          default:    state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.mem_we  = (d_iclass == C_SW);
        if (bus.mem_ack) state_nx = (d_iclass == C_SW) ? S_IF : S_WB;
      end
      S_WB: begin
        bus.rf_dst   = d_rf_dst;
        bus.wb_sel   = (d_iclass == C_LW) ? WB_MEM : WB_ALU;
        bus.rf_we    = ~ovf_q;
        bus.ovf_trap = ovf_q;
        state_nx     = S_IF;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_nx = S_IF;
    endcase

    if (state_nx == S_IF) ovf_nx = 1'b0;

    // The state register only reloads at the next edge, so the outputs are
    // forced quiet for the whole reset cycle, including any pending mem_ack.
    if (rst) begin
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.iord     = 1'b0;
      bus.ir_we    = 1'b0;
      bus.pc_we    = 1'b0;
      bus.pc_sel   = PC_INC;
      bus.aluc     = '0;
      bus.a_sel    = 1'b0;
      bus.b_sel    = 1'b0;
      bus.ext_sign = 1'b0;
      bus.aluo_we  = 1'b0;
      bus.rf_we    = 1'b0;
      bus.rf_dst   = RD_RT;
      bus.wb_sel   = WB_ALU;
      bus.ovf_trap = 1'b0;
      bus.halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu31_ctrl.sv
// tb/tb_cpu31_ctrl.sv - scoreboard bench for cpu31_ctrl
// Ports: none (top-level bench).

module tb_cpu31_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu31_if u_if ();

  cpu31_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [4:0] aluc;
    logic       a_sel;
    logic       b_sel;
    logic       ext_sign;
    logic       aluo_we;
    logic       rf_we;
    logic [1:0] rf_dst;
    logic [1:0] wb_sel;
    logic       ovf_trap;
    logic       halted;
  } out_t;

  out_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.mem_req  = u_if.mem_req;
    o.mem_we   = u_if.mem_we;
    o.iord     = u_if.iord;
    o.ir_we    = u_if.ir_we;
    o.pc_we    = u_if.pc_we;
    o.pc_sel   = u_if.pc_sel;
    o.aluc     = u_if.aluc;
    o.a_sel    = u_if.a_sel;
    o.b_sel    = u_if.b_sel;
    o.ext_sign = u_if.ext_sign;
    o.aluo_we  = u_if.aluo_we;
    o.rf_we    = u_if.rf_we;
    o.rf_dst   = u_if.rf_dst;
    o.wb_sel   = u_if.wb_sel;
    o.ovf_trap = u_if.ovf_trap;
    o.halted   = u_if.halted;
    return o;
  endfunction

  // Expected-output builders, one per control state.
  function automatic out_t e_zero();
    out_t e = '0;
    return e;
  endfunction

  function automatic out_t e_if(input logic ack);
    out_t e = '0;
    e.mem_req = 1'b1;
    e.ir_we   = ack;
    e.pc_we   = ack;
    return e;
  endfunction

  function automatic out_t e_ex(input logic [4:0] op, input logic as, input logic bs, input logic es);
    out_t e = '0;
    e.aluc     = op;
    e.a_sel    = as;
    e.b_sel    = bs;
    e.ext_sign = es;
    e.aluo_we  = 1'b1;
    return e;
  endfunction

  function automatic out_t e_br(input logic take);
    out_t e = e_ex(5'b00011, 1'b0, 1'b0, 1'b1);
    e.pc_we  = take;
    e.pc_sel = take ? 2'd1 : 2'd0;
    return e;
  endfunction

  function automatic out_t e_mem(input logic we);
    out_t e = '0;
    e.mem_req = 1'b1;
    e.iord    = 1'b1;
    e.mem_we  = we;
    return e;
  endfunction

  function automatic out_t e_wb(input logic we, input logic [1:0] dst, input logic [1:0] ws, input logic trap);
    out_t e = '0;
    e.rf_we    = we;
    e.rf_dst   = dst;
    e.wb_sel   = ws;
    e.ovf_trap = trap;
    return e;
  endfunction

  function automatic out_t e_jmp(input logic [1:0] sel, input logic link);
    out_t e = '0;
    e.pc_we  = 1'b1;
    e.pc_sel = sel;
    e.rf_we  = link;
    e.wb_sel = link ? 2'd2 : 2'd0;
    e.rf_dst = link ? 2'd2 : 2'd0;
    return e;
  endfunction

  function automatic out_t e_halt();
    out_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  // One clock cycle: drive inputs, record the expectation, then compare the
  // DUT against the oldest outstanding expectation.
  task automatic cyc(input string tag, input logic r, input logic [31:0] ins,
                     input logic ack, input logic zero, input logic ovf, input out_t e);
    out_t  o;
    out_t  x;
    string t;
    @(negedge clk);
    rst              = r;
    u_if.instr       = ins;
    u_if.mem_ack     = ack;
    u_if.alu_zero    = zero;
    u_if.alu_overflow = ovf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    o = sample();
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {9'b0, o}, {9'b0, x});
  endtask

  // ALU-class instruction: IF (optional wait cycles), ID, EX, WB.
  task automatic alu_op(input string nm, input logic [31:0] ins, input int waits,
                        input logic [4:0] op, input logic as, input logic bs, input logic es,
                        input logic [1:0] dst, input logic ovf, input logic trap);
    for (int i = 0; i < waits; i++) cyc({nm, "_if_wait"}, 1'b0, ins, 1'b0, 1'b0, 1'b0, e_if(1'b0));
    cyc({nm, "_if"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc({nm, "_id"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, e_zero());
    cyc({nm, "_ex"}, 1'b0, ins, 1'b1, 1'b0, ovf, e_ex(op, as, bs, es));
    cyc({nm, "_wb"}, 1'b0, ins, 1'b0, 1'b0, 1'b0, e_wb(~trap, dst, 2'd0, trap));
  endtask

  task automatic branch(input string nm, input logic [31:0] ins, input logic zero, input logic take);
    cyc({nm, "_if"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc({nm, "_id"}, 1'b0, ins, 1'b0, 1'b0, 1'b0, e_zero());
    cyc({nm, "_ex"}, 1'b0, ins, 1'b0, zero, 1'b0, e_br(take));
  endtask

  task automatic jump(input string nm, input logic [31:0] ins, input logic [1:0] sel, input logic link);
    cyc({nm, "_if"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc({nm, "_id"}, 1'b0, ins, 1'b0, 1'b0, 1'b0, e_jmp(sel, link));
  endtask

  initial begin
    u_if.instr        = '0;
    u_if.mem_ack      = 1'b0;
    u_if.alu_zero     = 1'b0;
    u_if.alu_overflow = 1'b0;

    cyc("reset0", 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, e_zero());
    cyc("reset1", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, e_zero());

    // addu, sll, add with overflow (trap), addu with overflow (no trap)
    alu_op("addu", 32'h00221821, 0, 5'b00000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    alu_op("sll",  32'h00031100, 0, 5'b01000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    alu_op("add",  32'h00221820, 0, 5'b00001, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    alu_op("addu_ovf", 32'h00221821, 0, 5'b00000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    alu_op("ori",  32'h34220005, 2, 5'b00101, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

    branch("beq_t", 32'h10220003, 1'b1, 1'b1);
    branch("beq_n", 32'h10220003, 1'b0, 1'b0);
    branch("bne_t", 32'h14220003, 1'b0, 1'b1);

    // lw with three wait cycles in MEM
    cyc("lw_if", 1'b0, 32'h8C220004, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc("lw_id", 1'b0, 32'h8C220004, 1'b0, 1'b0, 1'b0, e_zero());
    cyc("lw_ex", 1'b0, 32'h8C220004, 1'b0, 1'b0, 1'b0, e_ex(5'b10001, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 32'h8C220004, 1'b0, 1'b0, 1'b0, e_mem(1'b0));
    cyc("lw_mem_ack", 1'b0, 32'h8C220004, 1'b1, 1'b0, 1'b0, e_mem(1'b0));
    cyc("lw_wb", 1'b0, 32'h8C220004, 1'b0, 1'b0, 1'b0, e_wb(1'b1, 2'd0, 2'd1, 1'b0));

    // sw with same-cycle ack: 4 cycles
    cyc("sw_if", 1'b0, 32'hAC220004, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc("sw_id", 1'b0, 32'hAC220004, 1'b0, 1'b0, 1'b0, e_zero());
    cyc("sw_ex", 1'b0, 32'hAC220004, 1'b0, 1'b0, 1'b0, e_ex(5'b10001, 1'b0, 1'b1, 1'b1));
    cyc("sw_mem", 1'b0, 32'hAC220004, 1'b1, 1'b0, 1'b0, e_mem(1'b1));

    jump("j",   32'h08000010, 2'd2, 1'b0);
    jump("jal", 32'h0C000010, 2'd2, 1'b1);
    jump("jr",  32'h03E00008, 2'd3, 1'b0);

    // reset in MEM aborts the store even with mem_ack present
    cyc("swr_if", 1'b0, 32'hAC220004, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc("swr_id", 1'b0, 32'hAC220004, 1'b0, 1'b0, 1'b0, e_zero());
    cyc("swr_ex", 1'b0, 32'hAC220004, 1'b0, 1'b0, 1'b0, e_ex(5'b10001, 1'b0, 1'b1, 1'b1));
    cyc("swr_mem", 1'b0, 32'hAC220004, 1'b0, 1'b0, 1'b0, e_mem(1'b1));
    cyc("swr_rst", 1'b1, 32'hAC220004, 1'b1, 1'b0, 1'b0, e_zero());
    cyc("swr_after", 1'b0, 32'hAC220004, 1'b0, 1'b0, 1'b0, e_if(1'b0));

    // illegal opcode halts until reset
    cyc("ill_if", 1'b0, 32'hFC000000, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc("ill_id", 1'b0, 32'hFC000000, 1'b0, 1'b0, 1'b0, e_zero());
    for (int i = 0; i < 3; i++) cyc("ill_halt", 1'b0, 32'hFC000000, 1'b1, 1'b1, 1'b1, e_halt());
    cyc("ill_rst", 1'b1, 32'hFC000000, 1'b0, 1'b0, 1'b0, e_zero());
    cyc("ill_after", 1'b0, 32'h00221821, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    cyc("ill_after_id", 1'b0, 32'h00221821, 1'b0, 1'b0, 1'b0, e_zero());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu31_ctrl.md
# cpu31_ctrl

Multicycle control unit for the 31-instruction MIPS core. It decodes the latched instruction and sequences fetch, decode, execute, memory and writeback. Each cycle it drives the ALU opcode `aluc`, the operand selects and all datapath write strobes. It consumes the ALU `zero` and `overflow` flags to resolve branches and signed-add traps.

## Interface
- `ALUC_W`, 5: width of ALU opcode.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction register contents, valid from ID onward.
- `alu_zero`  in  1  ALU zero flag.
- `alu_overflow`  in  1  ALU signed-overflow flag.
- `mem_ack`  in  1  memory completion, one-cycle pulse.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  store qualifier, valid with `mem_req`.
- `iord`  out  1  address select: 0 = PC, 1 = ALU output register.
- `ir_we`  out  1  IR load strobe.
- `pc_we`  out  1  PC load strobe.
- `pc_sel`  out  2  PC source: 0 = PC+4, 1 = branch, 2 = jump, 3 = rs.
- `aluc`  out  5  ALU opcode.
- `a_sel`  out  1  ALU operand A: 0 = rs, 1 = zero-extended shamt.
- `b_sel`  out  1  ALU operand B: 0 = rt, 1 = extended imm16.
- `ext_sign`  out  1  imm16 extension: 1 = sign, 0 = zero.
- `aluo_we`  out  1  ALU output register load.
- `rf_we`  out  1  register-file write.
- `rf_dst`  out  2  destination: 0 = rt, 1 = rd, 2 = $31.
- `wb_sel`  out  2  write data: 0 = ALU out, 1 = memory data, 2 = PC.
- `ovf_trap`  out  1  one-cycle pulse on signed-add overflow.
- `halted`  out  1  high after an illegal instruction.

## Operation
- ALU opcode encoding is fixed:
  - ADDU 00000, ADD 00001, SUB 00010, SUBU 00011.
  - AND 00100, OR 00101, XOR 00110, NOR 00111.
  - SLL 01000, SRL 01001, SRA 01010, SLLV 01011.
  - LUI 01101, SRLV 01110, SRAV 01111.
  - LW/SW address 10001, SLT 10010, SLTU 10011.
- Supported instructions:
  - R-type: add addu sub subu and or xor nor slt sltu sll srl sra sllv srlv srav jr.
  - I-type: addi addiu andi ori xori lui lw sw beq bne slti sltiu.
  - J-type: j jal.
- Anything else is illegal.
- Mapping rules:
  - addi → ADD, addiu → ADDU, andi/ori/xori → AND/OR/XOR, slti/sltiu → SLT/SLTU, lui → LUI.
  - beq/bne → SUBU, so that no overflow is raised.
  - sll/srl/sra → `a_sel`=1, because the ALU shifts by all of operand A.
  - sllv/srlv/srav → `a_sel`=0.
- `ext_sign`=0 only for andi/ori/xori. It is 1 otherwise.
- `rf_dst`: 1 for R-type, 2 for jal, 0 otherwise.
- States:
  - IF: `mem_req`=1, `iord`=0. On `mem_ack`, assert `ir_we` and `pc_we` (`pc_sel`=0), go to ID.
  - ID: decode.
    - j: `pc_we`, `pc_sel`=2, go to IF.
    - jal: same as j, plus `rf_we`, `wb_sel`=2, `rf_dst`=2, go to IF.
    - jr: `pc_we`, `pc_sel`=3, go to IF.
    - illegal: go to HALT.
    - else: go to EX.
  - EX: drive `aluc` and `aluo_we`=1. The overflow flag is registered into `ovf_q`.
    - beq/bne: assert `pc_we`, `pc_sel`=1 iff (`alu_zero` xor bne), then go to IF.
    - lw/sw: go to MEM.
    - else: go to WB.
  - MEM: `mem_req`=1, `iord`=1, `mem_we`=sw. On `mem_ack`, sw goes to IF and lw goes to WB.
  - WB: normally `rf_we`=1.
    - `wb_sel`=1 for lw, 0 otherwise.
    - If `ovf_q` (add/addi/sub only), `rf_we`=0 and `ovf_trap`=1.
    - Always go to IF.
  - HALT: all strobes 0, `halted`=1. Only `rst` exits.

## Timing
- Outputs are combinational from the state register, the IR fields, the flags and `mem_ack`.
- While `rst` is high, every output is 0 and state is loaded to IF.
- `mem_req` first rises in the cycle after `rst` falls.
- Cycle counts with a same-cycle `mem_ack`:
  - ALU ops: 4.
  - lw: 5.
  - sw: 4.
  - branches: 3.
  - j/jal/jr: 2.
- Each added wait cycle on `mem_ack` adds one cycle. During the wait, `mem_req`, `mem_we` and `iord` hold stable.
- `mem_ack` while `mem_req` is low is ignored.
- `rst` mid-MEM aborts the access and no strobe fires. `rst` has priority over `mem_ack` in the same cycle.
- `ovf_q` is cleared on entry to IF.

## Structure
- Package `cpu31_pkg` holds:
  - aluc constants;
  - opcode and funct constants;
  - the state enum (IF, ID, EX, MEM, WB, HALT);
  - the `pc_sel`, `rf_dst` and `wb_sel` codes.
- Sub-module `cpu31_decode` is a combinational decoder. It takes opcode and funct and produces the instruction class, `aluc`, `a_sel`, `b_sel`, `ext_sign`, `rf_dst` and `illegal`.
- `cpu31_ctrl` holds the FSM and `ovf_q`.

## Test plan
- `instr`=0x00221821 (addu $3,$1,$2), `mem_ack` on the first IF cycle:
  - EX: `aluc`=00000.
  - WB: `rf_we`=1, `rf_dst`=1.
  - Next IF follows 4 cycles after the first.
- 0x00031100 (sll $2,$3,4): EX has `aluc`=01000, `a_sel`=1, `b_sel`=0.
- 0x00221820 (add) with `alu_overflow`=1 in EX: WB has `rf_we`=0 and `ovf_trap` is a 1-cycle pulse.
- 0x10220003 (beq) in EX:
  - `aluc`=00011.
  - `alu_zero`=1 gives `pc_we`=1, `pc_sel`=1.
  - `alu_zero`=0 gives `pc_we`=0.
- 0x8C220004 (lw), `mem_ack` delayed 3 cycles in MEM:
  - `mem_req` and `iord` stay 1 for 4 cycles.
  - EX has `aluc`=10001.
  - WB has `wb_sel`=1, `rf_dst`=0.
- Opcode 0x3F gives `halted`=1 with all strobes 0 until `rst`. `rst` during MEM returns to IF with no `mem_we`.
